// File: rtl/calc_sequencer.sv
// Instruction sequencer for a register-file/ALU calculator.
// Accepts one 16-bit instruction at a time and drives the calculator's control ports.
module calc_sequencer #(
    parameter logic [3:0] CTRL_PASSX = 4'b0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        WEN,
    output logic [2:0]  RW,
    output logic [2:0]  RX,
    output logic [2:0]  RY,
    output logic [7:0]  DataIn,
    output logic        Sel,
    output logic [3:0]  Ctrl,
    input  logic [7:0]  busY,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a word transfers on a rising Clk edge where in_valid and
    // in_ready are both high; the source must hold the word until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        READ = 2'd2,
        REP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOADI  = 2'b00;
    localparam logic [1:0] OP_ALU    = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_REPEAT = 2'b11;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wen_q, wen_d;
    logic [2:0] rw_q, rw_d, rx_q, rx_d, ry_q, ry_d;
    logic [7:0] datain_q, datain_d;
    logic       sel_q, sel_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;

    logic [1:0] f_op;
    logic [2:0] f_rd, f_rx, f_ry, f_cnt;
    logic [3:0] f_ctrl;
    logic [7:0] f_imm;

    assign f_op   = in_instr[15:14];
    assign f_rd   = in_instr[13:11];
    assign f_rx   = in_instr[10:8];
    assign f_cnt  = in_instr[10:8];
    assign f_ry   = in_instr[7:5];
    assign f_ctrl = in_instr[3:0];
    assign f_imm  = in_instr[7:0];

    // Gated by Rst so no source sees a ready while the block is held in reset.
    assign in_ready = (state_q == IDLE) && !Rst;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            wen_q       <= 1'b0;
            rw_q        <= 3'd0;
            rx_q        <= 3'd0;
            ry_q        <= 3'd0;
            datain_q    <= 8'd0;
            sel_q       <= 1'b0;
            ctrl_q      <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            rw_q        <= rw_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            datain_q    <= datain_d;
            sel_q       <= sel_d;
            ctrl_q      <= ctrl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wen_d       = 1'b0;
        rw_d        = rw_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        datain_d    = datain_q;
        sel_d       = sel_q;
        ctrl_d      = ctrl_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (f_op)
                        OP_LOADI: begin
                            state_d  = EXEC;
                            wen_d    = 1'b1;
                            rw_d     = f_rd;
                            sel_d    = 1'b0;
                            datain_d = f_imm;
                            ctrl_d   = CTRL_PASSX;
                        end
                        OP_ALU: begin
                            state_d = EXEC;
                            wen_d   = 1'b1;
                            rw_d    = f_rd;
                            rx_d    = f_rx;
                            ry_d    = f_ry;
                            sel_d   = 1'b1;
                            ctrl_d  = f_ctrl;
                        end
                        OP_READ: begin
                            state_d = READ;
                            ry_d    = f_ry;
                        end
                        OP_REPEAT: begin
                            // rd is both source X and destination: rd <= rd ctrl ry.
                            state_d = REP;
                            cnt_d   = f_cnt;
                            wen_d   = 1'b1;
                            rw_d    = f_rd;
                            rx_d    = f_rd;
                            ry_d    = f_ry;
                            sel_d   = 1'b1;
                            ctrl_d  = f_ctrl;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            EXEC: state_d = IDLE;
            READ: begin
                res_data_d  = busY;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            REP: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    wen_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign WEN         = wen_q;
    assign RW          = rw_q;
    assign RX          = rx_q;
    assign RY          = ry_q;
    assign DataIn      = datain_q;
    assign Sel         = sel_q;
    assign Ctrl        = ctrl_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small register-file/ALU calculator model.
module tb_calc_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_REP  = 2'd3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0000;
    logic        WEN;
    logic [2:0]  RW, RX, RY;
    logic [7:0]  DataIn;
    logic        Sel;
    logic [3:0]  Ctrl;
    logic [7:0]  busY;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    calc_sequencer #(.CTRL_PASSX(4'b0000)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .WEN(WEN), .RW(RW), .RX(RX), .RY(RY),
        .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl), .busY(busY),
        .res_valid(res_valid), .res_data(res_data), .dbg_state_o(dbg_state)
    );

    always #5 Clk = ~Clk;

    // Calculator model: Ctrl 0 = pass X, 1 = add, 2 = sub, others = and.
    logic [7:0] regs [8] = '{default: 8'h00};
    int         wr0_total = 0;
    logic [7:0] op_x;
    logic [7:0] alu_y;

    assign busY  = regs[RY];
    assign op_x  = Sel ? regs[RX] : DataIn;
    always_comb begin
        case (Ctrl)
            4'd0:    alu_y = op_x;
            4'd1:    alu_y = op_x + regs[RY];
            4'd2:    alu_y = op_x - regs[RY];
            default: alu_y = op_x & regs[RY];
        endcase
    end

    always @(posedge Clk) begin
        if (WEN) begin
            regs[RW] <= alu_y;
            if (RW == 3'd0) wr0_total <= wr0_total + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents a word and returns #1 after the accepting edge (first cycle of execution).
    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = w;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("send_timeout", 8'd1, 8'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] r, input logic [7:0] exp);
        send({2'b10, 6'd0, r, 5'd0});
        check({tag, "_ry"}, 8'(RY), 8'(r));
        check({tag, "_wen"}, 8'(WEN), 8'd0);
        tick();
        check({tag, "_valid"}, 8'(res_valid), 8'd1);
        check({tag, "_data"}, res_data, exp);
        tick();
        check({tag, "_pulse_end"}, 8'(res_valid), 8'd0);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 8'(in_ready), 8'd0);
        check("rst_wen", 8'(WEN), 8'd0);
        check("rst_rw", 8'(RW), 8'd0);
        check("rst_datain", DataIn, 8'd0);
        check("rst_resv", 8'(res_valid), 8'd0);
        check("rst_state", 8'(dbg_state), 8'(S_IDLE));
        Rst = 1'b0;
        #1;
        check("rel_ready", 8'(in_ready), 8'd1);
        tick();

        // LOADI r3 <= A5
        send(16'h18A5);
        check("ldi_wen", 8'(WEN), 8'd1);
        check("ldi_rw", 8'(RW), 8'd3);
        check("ldi_sel", 8'(Sel), 8'd0);
        check("ldi_datain", DataIn, 8'hA5);
        check("ldi_ctrl", 8'(Ctrl), 8'd0);
        check("ldi_ready", 8'(in_ready), 8'd0);
        check("ldi_state", 8'(dbg_state), 8'(S_EXEC));
        tick();
        check("ldi_wen_off", 8'(WEN), 8'd0);
        check("ldi_idle_ready", 8'(in_ready), 8'd1);
        do_read("rd_r3", 3'd3, 8'hA5);

        // ALU r1 = r2 + r4 with r2 = 5, r4 = 3
        send(16'h1005);
        send(16'h2003);
        send(16'h4A81);
        check("alu_wen", 8'(WEN), 8'd1);
        check("alu_rw", 8'(RW), 8'd1);
        check("alu_rx", 8'(RX), 8'd2);
        check("alu_ry", 8'(RY), 8'd4);
        check("alu_sel", 8'(Sel), 8'd1);
        check("alu_ctrl", 8'(Ctrl), 8'd1);
        tick();
        check("alu_wen_off", 8'(WEN), 8'd0);
        do_read("rd_r1", 3'd1, 8'h08);

        // REPEAT r0 += r1 four times (r0 = 0, r1 = 1)
        send(16'h0000);
        send(16'h0801);
        send(16'hC321);
        for (int i = 0; i < 4; i++) begin
            check("rep_wen", 8'(WEN), 8'd1);
            check("rep_ready", 8'(in_ready), 8'd0);
            check("rep_state", 8'(dbg_state), 8'(S_REP));
            tick();
        end
        check("rep_wen_off", 8'(WEN), 8'd0);
        check("rep_done_ready", 8'(in_ready), 8'd1);
        do_read("rd_r0", 3'd0, 8'h04);

        // Two queued words with in_valid held high
        in_valid = 1'b1;
        in_instr = 16'h2811;
        tick();
        in_instr = 16'h3022;
        check("b2b_ready_k1", 8'(in_ready), 8'd0);
        check("b2b_rw_first", 8'(RW), 8'd5);
        tick();
        check("b2b_ready_k2", 8'(in_ready), 8'd1);
        check("b2b_wen_gap", 8'(WEN), 8'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_wen_second", 8'(WEN), 8'd1);
        check("b2b_rw_second", 8'(RW), 8'd6);
        check("b2b_datain_second", DataIn, 8'h22);
        tick();
        check("b2b_idle", 8'(dbg_state), 8'(S_IDLE));
        do_read("rd_r5", 3'd5, 8'h11);
        do_read("rd_r6", 3'd6, 8'h22);

        // Reset in the 2nd cycle of REPEAT cnt = 7
        send(16'h0000);
        tick();
        base = wr0_total;
        send(16'hC721);
        tick();
        check("rep7_state", 8'(dbg_state), 8'(S_REP));
        Rst = 1'b1;
        #1;
        check("rep7_rst_wen", 8'(WEN), 8'd0);
        check("rep7_rst_state", 8'(dbg_state), 8'(S_IDLE));
        check("rep7_rst_ready", 8'(in_ready), 8'd0);
        tick();
        Rst = 1'b0;
        #1;
        check("rep7_writes", 8'(wr0_total - base), 8'd1);
        check("rep7_rel_ready", 8'(in_ready), 8'd1);
        check("rep7_rel_state", 8'(dbg_state), 8'(S_IDLE));
        tick();
        check("rep7_wen_after", 8'(WEN), 8'd0);
        check("rep7_writes_after", 8'(wr0_total - base), 8'd1);
        do_read("rd_r0_abort", 3'd0, 8'h01);

        // Reset during READ
        send(16'h8060);
        check("rdrst_state", 8'(dbg_state), 8'(S_READ));
        Rst = 1'b1;
        #1;
        check("rdrst_valid", 8'(res_valid), 8'd0);
        check("rdrst_data", res_data, 8'd0);
        tick();
        Rst = 1'b0;
        #1;
        check("rdrst_valid_rel", 8'(res_valid), 8'd0);
        check("rdrst_data_rel", res_data, 8'd0);
        check("rdrst_state_rel", 8'(dbg_state), 8'(S_IDLE));
        tick();
        check("rdrst_valid_after", 8'(res_valid), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
